// File: rtl/nios2_debug_ocimem_arbiter.sv
// Arbitrates the debug monitor RAM between the CPU debug slave and
// JTAG ocimem commands, returning JTAG results through MonDReg.
module nios2_debug_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU_RD,
    S_JTAG_RD
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
  logic [DATA_W-1:0]   mon_d_q, mon_d_d;
  logic [DATA_W-1:0]   jdata_q, jdata_d;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                jpend_q, jpend_d;
  logic                jwr_q, jwr_d;
  logic                ready_q, ready_d;
  logic                ovr_q, ovr_d;
  logic                last_jtag_q, last_jtag_d;

  logic cpu_req, grant_jtag, grant_cpu;
  logic strobe, accept, queue, jdone, cpu_done;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign cpu_req = avs_read | avs_write;
  assign strobe  = take_action_ocimem_a | take_action_ocimem_b
                 | take_no_action_ocimem_a;
  assign accept  = strobe & ~jpend_q;
  assign queue   = accept & (take_action_ocimem_b
                 | take_no_action_ocimem_a
                 | (take_action_ocimem_a & jdo[34]));

  // On contention the side that did not win last time goes first.
  assign grant_jtag = (state_q == S_IDLE) & jpend_q
                    & (~cpu_req | ~last_jtag_q);
  assign grant_cpu  = (state_q == S_IDLE) & cpu_req & ~grant_jtag;

  assign jdone    = (grant_jtag & jwr_q) | (state_q == S_JTAG_RD);
  assign cpu_done = (grant_cpu & avs_write) | (state_q == S_CPU_RD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      jdata_q     <= '0;
      ram_addr_q  <= '0;
      jpend_q     <= 1'b0;
      jwr_q       <= 1'b0;
      ready_q     <= 1'b1;
      ovr_q       <= 1'b0;
      last_jtag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mon_a_q     <= mon_a_d;
      mon_d_q     <= mon_d_d;
      jdata_q     <= jdata_d;
      ram_addr_q  <= ram_addr;
      jpend_q     <= jpend_d;
      jwr_q       <= jwr_d;
      ready_q     <= ready_d;
      ovr_q       <= ovr_d;
      last_jtag_q <= last_jtag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mon_a_d     = mon_a_q;
    mon_d_d     = mon_d_q;
    jdata_d     = jdata_q;
    jpend_d     = jpend_q;
    jwr_d       = jwr_q;
    ready_d     = ready_q;
    ovr_d       = ovr_q | (strobe & jpend_q);
    last_jtag_d = last_jtag_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_cpu & ~avs_write) state_d = S_CPU_RD;
        if (grant_jtag & ~jwr_q)    state_d = S_JTAG_RD;
      end
      S_CPU_RD:  state_d = S_IDLE;
      S_JTAG_RD: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (grant_jtag) last_jtag_d = 1'b1;
    if (grant_cpu)  last_jtag_d = 1'b0;
    if (accept & take_action_ocimem_a) mon_a_d = jdo[10 +: ADDR_W];
    if (queue) begin
      jpend_d = 1'b1;
      ready_d = 1'b0;
      jwr_d   = take_action_ocimem_b;
      if (take_action_ocimem_b) jdata_d = jdo[3 +: DATA_W];
    end
    if (jdone) begin
      mon_a_d = mon_a_q + 1'b1;
      mon_d_d = (state_q == S_JTAG_RD) ? ram_rdata : jdata_q;
      jpend_d = 1'b0;
      ready_d = 1'b1;
    end
  end

  always_comb begin
    ram_addr  = ram_addr_q;
    ram_wr    = 1'b0;
    ram_be    = 4'h0;
    ram_wdata = '0;
    if (grant_cpu) begin
      ram_addr = avs_address;
      if (avs_write) begin
        ram_wr    = 1'b1;
        ram_be    = avs_byteenable;
        ram_wdata = avs_writedata;
      end
    end else if (grant_jtag) begin
      ram_addr = mon_a_q;
      if (jwr_q) begin
        ram_wr    = 1'b1;
        ram_be    = 4'hF;
        ram_wdata = jdata_q;
      end
    end
    if (reset) ram_wr = 1'b0;
    avs_waitrequest = cpu_req & ~cpu_done;
  end

  assign avs_readdata  = ram_rdata;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign jtag_overrun  = ovr_q;

endmodule

// File: doc/nios2_debug_ocimem_arbiter.md
Name: nios2_debug_ocimem_arbiter

Overview:
- Shares the single-port 256x32 debug monitor RAM between two requesters: the CPU's Avalon-MM debug memory slave and JTAG ocimem commands from the debug slave's system-clock take_action strobes.
- Sequences JTAG address-load, write and streaming-read commands.
- Returns read data to the JTAG debug slave via MonDReg and monitor_ready.
- Sits between the debug slave wrapper and the monitor RAM inside the CPU's on-chip instrumentation block.

Parameters:
- ADDR_W, 8, monitor RAM word-address width.
- DATA_W, 32, data width (fixed 32; jdo field positions depend on it).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- jdo  in  38  JTAG data from the debug slave; sampled only on a strobe cycle
- take_action_ocimem_a  in  1  pulse: load address; optionally read
- take_action_ocimem_b  in  1  pulse: write data at current address
- take_no_action_ocimem_a  in  1  pulse: streaming read at current address
- avs_address  in  ADDR_W  CPU word address
- avs_read  in  1  CPU read request
- avs_write  in  1  CPU write request
- avs_writedata  in  32  CPU write data
- avs_byteenable  in  4  CPU byte enables
- avs_readdata  out  32  CPU read data
- avs_waitrequest  out  1  CPU stall
- ram_addr  out  ADDR_W  RAM address
- ram_wr  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_be  out  4  RAM byte enables
- ram_rdata  in  32  RAM read data, valid 1 cycle after address
- MonDReg  out  32  last JTAG read/write data
- monitor_ready  out  1  JTAG command complete
- jtag_overrun  out  1  sticky: JTAG strobe dropped

Behaviour:
Reset values:
- All registers clear: MonAReg=0, MonDReg=0, monitor_ready=1, jtag_overrun=0, state=IDLE, last_grant=CPU, jpend=0.
- Reset mid-transaction abandons it; no RAM write occurs in the reset cycle.

JTAG decode (only when jpend=0; at most one strobe per cycle):
- ocimem_a: MonAReg<=jdo[17:10]. If jdo[34]=1, queue read; otherwise no RAM access and monitor_ready stays 1.
- ocimem_b: queue write of jdo[34:3].
- no_action_ocimem_a: queue read at MonAReg.
- Queuing sets jpend=1 and monitor_ready<=0 in the next cycle.
- Any strobe while jpend=1 is dropped and sets jtag_overrun. jtag_overrun clears only on reset.

FSM IDLE / CPU_RD / JTAG_RD:
- IDLE, with a CPU request (avs_read|avs_write) and/or jpend:
  - Grant the only requester; if both request, grant the opposite of last_grant.
  - Update last_grant on every grant.
- CPU write grant:
  - ram_addr=avs_address, ram_wr=1, ram_be=avs_byteenable, ram_wdata=avs_writedata.
  - avs_waitrequest=0 in the same cycle; stay in IDLE.
- CPU read grant:
  - Drive the address; go to CPU_RD.
- CPU_RD:
  - avs_readdata=ram_rdata, avs_waitrequest=0; return to IDLE.
- JTAG write grant:
  - ram_wr=1, ram_be=4'hF, ram_addr=MonAReg.
  - MonDReg<=data, MonAReg<=MonAReg+1 (8-bit wrap, 0xFF->0x00).
  - jpend<=0, monitor_ready<=1; stay in IDLE.
- JTAG read grant:
  - Drive MonAReg; go to JTAG_RD.
- JTAG_RD:
  - MonDReg<=ram_rdata, MonAReg+1 (wrap), jpend<=0, monitor_ready<=1; return to IDLE.
- avs_waitrequest=1 whenever avs_read|avs_write is asserted and the transfer is not completing in that cycle. It is 0 when no CPU request is present.
- ram_wr=0 outside write grants. ram_addr holds its last value when idle.
- Worst-case CPU wait with JTAG contention is 2 cycles. Neither requester can starve the other.

Test Plan:
- Reset, then idle -> monitor_ready=1, avs_waitrequest=0, ram_wr=0, MonDReg=0, jtag_overrun=0.
- ocimem_a with jdo[17:10]=0x10, jdo[34]=0; then ocimem_b with data 0xDEADBEEF -> ram_wr at addr 0x10 with be=F; MonAReg=0x11; monitor_ready low for 1 cycle then 1.
- CPU read at addr 0x10 -> waitrequest high 1 cycle; avs_readdata=0xDEADBEEF.
- ocimem_a with addr 0xFF and read, then no_action_ocimem_a -> two reads at 0xFF then 0x00; MonDReg tracks each read; MonAReg ends at 0x01.
- CPU write held while JTAG read is pending, same cycle, last_grant=CPU -> JTAG granted first. CPU write completes 2 cycles later; next contention grants CPU.
- Second ocimem_b while jpend=1 -> command ignored (one RAM write only); jtag_overrun=1 until reset.
